// File: rtl/int_vec_packer.sv
// int_vec_packer
//   Packs a stream of WORD_W-bit integer words into LANES-wide vectors for the
//   downstream adder tree. Word k of a vector lands in lane k (lane 0 in the
//   LSBs). A vector closes on its LANES-th word or on any word carrying
//   in_last. The packed vector is then presented for exactly one cycle
//   (EMIT). During that cycle the packer does not accept input.
//   Lanes that were never written read as zero, so the downstream sum of an
//   early-closed vector is unaffected.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream word present
//   in_data    upstream word
//   in_last    closes the vector on this word (qualified by in_valid)
//   in_ready   packer accepts a word this cycle (high in FILL)
//   valid_out  one-cycle pulse, data_out/lanes_out carry a packed vector
//   data_out   packed vector, LANES*WORD_W bits
//   lanes_out  number of populated lanes in the emitted vector (1..LANES)
//   vec_count  (only with INT_VEC_PACKER_CNT_EN) emitted-vector count, wraps
//
// Configuration
//   INT_VEC_PACKER_CNT_EN  adds the 16-bit vec_count output and its counter.

// One lane of the packing buffer. Clearing takes priority over writing. The
// FSM never requests both in the same cycle.
module int_vec_packer_lane #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              clr,
  input  logic [WORD_W-1:0] d,
  output logic [WORD_W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q <= '0;
    else if (clr)   q <= '0;
    else if (wr_en) q <= d;
  end
endmodule

module int_vec_packer #(
  parameter int WORD_W = 32,
  parameter int LANES  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [WORD_W-1:0]       in_data,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    valid_out,
  output logic [LANES*WORD_W-1:0] data_out,
  output logic [3:0]              lanes_out
`ifdef INT_VEC_PACKER_CNT_EN
  ,
  output logic [15:0]             vec_count
`endif
);
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic {FILL, EMIT} state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [3:0]                     lanes_q;
  logic [LANES-1:0][WORD_W-1:0]   buf_q;
  logic                           accept, close;

  assign accept = in_valid & in_ready;
  assign close  = accept & (in_last | (cnt_q == CNT_W'(LANES-1)));

  // Next state / outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    valid_out = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (close) begin
          state_d = EMIT;
          cnt_d   = '0;
        end else if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      EMIT: begin
        valid_out = 1'b1;
        state_d   = FILL;
        cnt_d     = '0;
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Populated-lane count is captured with the closing word. It stays put
  // through EMIT and is only meaningful while valid_out is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     lanes_q <= '0;
    else if (close) lanes_q <= 4'(cnt_q) + 4'd1;
  end

  // Packing buffer. The closing word is written on the same edge that enters
  // EMIT, so the buffer itself is the emitted vector. Leaving EMIT clears it,
  // which is what zeroes unpopulated lanes of the next vector.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    int_vec_packer_lane #(.WORD_W(WORD_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (accept && (cnt_q == CNT_W'(k))),
      .clr   (state_q == EMIT),
      .d     (in_data),
      .q     (buf_q[k])
    );
  end

  assign data_out  = buf_q;
  assign lanes_out = lanes_q;

`ifdef INT_VEC_PACKER_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                vec_count <= '0;
    else if (state_q == EMIT)  vec_count <= vec_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_int_vec_packer.sv
module tb_int_vec_packer;
  localparam int W = 32;
  localparam int L = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_last;
  logic           in_ready;
  logic           valid_out;
  logic [L*W-1:0] data_out;
  logic [3:0]     lanes_out;
`ifdef INT_VEC_PACKER_CNT_EN
  logic [15:0]    vec_count;
  logic [15:0]    m_vec_cnt;
`endif

  int_vec_packer #(.WORD_W(W), .LANES(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .valid_out (valid_out),
    .data_out  (data_out),
    .lanes_out (lanes_out)
`ifdef INT_VEC_PACKER_CNT_EN
    ,
    .vec_count (vec_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [L*W-1:0] data;
    logic [3:0]     lanes;
    logic [W+3:0]   sum;
  } exp_t;

  exp_t        exp_q[$];
  logic [W-1:0] cur[$];
  bit          m_ready;
  int          n_total = 0;
  int          n_pass  = 0;

  task automatic chk(input string name, input logic [L*W-1:0] act, input logic [L*W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: a word is taken whenever the packer is ready; a vector is
  // the list of words taken since the last close. After a close the packer
  // spends one cycle presenting it and takes nothing.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur.delete();
      exp_q.delete();
      m_ready = 1'b1;
`ifdef INT_VEC_PACKER_CNT_EN
      m_vec_cnt = '0;
`endif
    end else if (!m_ready) begin
      m_ready = 1'b1;
    end else if (in_valid) begin
      cur.push_back(in_data);
      if (in_last || cur.size() == L) begin
        exp_t e;
        e.data  = '0;
        e.sum   = '0;
        e.lanes = 4'(cur.size());
        foreach (cur[i]) begin
          e.data[i*W +: W] = cur[i];
          e.sum = e.sum + (W+4)'(cur[i]);
        end
        exp_q.push_back(e);
        cur.delete();
        m_ready = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, m_ready);
      chk("valid_out", valid_out, !m_ready);
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_pulse: got valid_out=1 expected no vector pending");
        end else begin
          exp_t e;
          logic [W+3:0] s;
          e = exp_q.pop_front();
          s = '0;
          for (int i = 0; i < L; i++) s = s + (W+4)'(data_out[i*W +: W]);
          chk("data_out", data_out, e.data);
          chk("lanes_out", lanes_out, e.lanes);
          chk("lane_sum", s, e.sum);
`ifdef INT_VEC_PACKER_CNT_EN
          m_vec_cnt = m_vec_cnt + 16'd1;
`endif
        end
      end
`ifdef INT_VEC_PACKER_CNT_EN
      chk("vec_count", vec_count, m_vec_cnt);
`endif
    end
  end

  // Drive one word and hold it until the packer takes it. Called at a time
  // between a negedge and the next posedge.
  task automatic send(input logic [W-1:0] d, input logic last);
    bit acc;
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    do begin
      acc = m_ready;
      @(negedge clk);
      n++;
    end while (!acc && n < 20);
    if (!acc) begin
      n_total++;
      $display("FAIL send_timeout: got no acceptance expected acceptance within 20 cycles");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = $urandom;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_data_out", data_out, '0);
    chk("rst_lanes_out", lanes_out, 4'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Full vector 1..8
    for (int i = 1; i <= 8; i++) send(W'(i), 1'b0);
    idle(3);

    // Early close A,B,C
    send(32'hA, 1'b0);
    send(32'hB, 1'b0);
    send(32'hC, 1'b1);
    idle(3);

    // Back-to-back 16 words, in_valid held
    for (int i = 9; i <= 24; i++) send(W'(i), 1'b0);
    idle(3);

    // Gaps over 8 words, then a single all-ones word
    for (int i = 0; i < 8; i++) begin
      send(W'(32'h100 + i), 1'b0);
      idle(1);
    end
    send(32'hFFFF_FFFF, 1'b1);
    idle(3);

    // Reset mid-operation after 5 words
    for (int i = 0; i < 5; i++) send(W'(32'h50 + i), 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid_out", valid_out, 1'b0);
    chk("midrst_data_out", data_out, '0);
    chk("midrst_lanes_out", lanes_out, 4'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) send(W'(32'h900 + i), 1'b0);
    idle(3);

    // Reset with a vector pending EMIT: no pulse may follow
    for (int i = 0; i < 3; i++) send(W'(32'h70 + i), i == 2);
    #2 rst_n = 1'b0;
    #1;
    chk("emitrst_valid_out", valid_out, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(3);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send($urandom, $urandom_range(0, 5) == 0);
    end
    idle(5);
    chk("scoreboard_drained", 256'(exp_q.size()), 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/int_vec_packer.md
INT_VEC_PACKER -- requirements
Module: int_vec_packer

Interface
REQ-001 SHALL have parameter WORD_W, default 32, width of one input integer word.
REQ-002 SHALL have parameter LANES, default 8, number of words packed per output vector; only LANES=8 is verified.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream word present.
REQ-006 SHALL have port in_data  input  WORD_W  upstream integer word.
REQ-007 SHALL have port in_last  input  1  marks the final word of a vector; qualified by in_valid.
REQ-008 SHALL have port in_ready  output  1  packer can accept a word this cycle.
REQ-009 SHALL have port valid_out  output  1  single-cycle pulse; packed vector is present on data_out.
REQ-010 SHALL have port data_out  output  LANES*WORD_W (256)  packed vector; drives the 256-bit data_in of the downstream adder tree.
REQ-011 SHALL have port lanes_out  output  4  number of populated lanes (1..8) in the emitted vector.

Function
REQ-012 SHALL accept a word only on a rising edge where in_valid=1 and in_ready=1.
REQ-013 SHALL place the k-th accepted word of a vector (k=0..7) at data_out[k*32+31 : k*32].
REQ-014 SHALL implement two states: FILL (in_ready=1, valid_out=0) and EMIT (in_ready=0, valid_out=1).
REQ-015 SHALL have a 3-bit lane counter in FILL, incremented per accepted word.
REQ-016 SHALL transition FILL->EMIT on acceptance of the 8th word (counter=7) or on any accepted word with in_last=1.
REQ-017 SHALL remain in EMIT for exactly one cycle and then return to FILL with the counter at 0.
REQ-018 SHALL assert valid_out in the cycle immediately following acceptance of the closing word; latency is 1 cycle; throughput is 8 words per 9 cycles.
REQ-019 SHALL hold data_out and lanes_out stable throughout the EMIT cycle.
REQ-020 SHALL output zero in all unpopulated lanes when a vector is closed early by in_last, so the downstream sum is unaffected.
REQ-021 SHALL set lanes_out to the counter value plus 1 at the closing word; a full vector gives 8, and in_last on the 8th word also gives 8.
REQ-022 SHALL clear the packing buffer to zero on the EMIT->FILL transition; data_out is valid only while valid_out=1.
REQ-023 SHALL ignore in_data and in_last while in_ready=0; the upstream stage must hold its word until in_ready=1.
REQ-024 SHALL keep the counter, the state and the buffer unchanged in FILL cycles with in_valid=0, with no timeout.

Reset
REQ-025 SHALL asynchronously force the following on rst_n=0: state=FILL, counter=0, buffer=0, valid_out=0, data_out=0, lanes_out=0, in_ready=1 (after reset release).
REQ-026 SHALL discard a partially filled vector or a pending EMIT on reset mid-operation; no valid_out pulse follows reset release until a new vector closes.

Configuration
REQ-027 SHALL, with macro INT_VEC_PACKER_CNT_EN defined, add output vec_count (16 bits), which increments by 1 at each valid_out pulse, wraps from 65535 to 0, and resets to 0.
REQ-028 SHALL, with INT_VEC_PACKER_CNT_EN undefined, neither have port vec_count nor its counter, with all other behaviour identical.

Verification
REQ-029 SHALL test the full vector: words 1..8 on consecutive cycles with in_last=0 -> one valid_out pulse 1 cycle after word 8, data_out={8,7,6,5,4,3,2,1} (word 1 in LSBs), lanes_out=8, and the downstream sum is 36.
REQ-030 SHALL test the early close: words 0xA, 0xB, 0xC with in_last on 0xC -> valid_out 1 cycle later, lanes 0..2 = A,B,C, lanes 3..7 = 0, lanes_out=3.
REQ-031 SHALL test back-to-back vectors: 16 words with in_valid held at 1 -> in_ready=0 for exactly one cycle after word 8, word 9 accepted on the next cycle, and a second pulse carries words 9..16 with no stale lanes.
REQ-032 SHALL test gaps and a single word: in_valid toggling 1/0 over 8 words -> a single pulse with the correct packing; then one word 0xFFFFFFFF with in_last=1 -> lanes_out=1 and the upper 224 bits are 0.
REQ-033 SHALL test reset mid-operation: 5 words accepted, then rst_n=0 for 1 cycle -> outputs zero immediately, no pulse; the next 8 words produce one pulse containing only those words.
REQ-034 SHALL test the counter macro: with INT_VEC_PACKER_CNT_EN defined, after 65537 emitted vectors vec_count=1.
